// File: rtl/fb_line_fetch.sv
// Framebuffer line fetcher: issues one-at-a-time SRAM reads for a line of
// 16-bit words and streams them out through a small first-word-fall-through FIFO.
module fb_line_fetch #(
  parameter int LINE_WORDS = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_line_base,
  output logic        o_busy,
  output logic        o_line_done,
  output logic        o_sram_read,
  output logic        o_sram_write,
  output logic [31:0] o_sram_addr,
  input  logic [15:0] i_sram_data,
  input  logic        i_sram_done,
  output logic [15:0] o_pix_data,
  output logic        o_pix_valid,
  input  logic        i_pix_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [15:0]    LAST_IDX = 16'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;

  state_t         state, state_nxt;
  logic [31:0]    base;
  logic [15:0]    word_cnt;
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] occupancy;
  logic [15:0]    mem [FIFO_DEPTH];
  logic           push, pop, room, last_word;

  assign occupancy    = wr_ptr - rd_ptr;
  assign o_pix_valid  = (occupancy != '0);
  assign o_pix_data   = o_pix_valid ? mem[rd_ptr[PTR_W-1:0]] : 16'd0;
  assign pop          = o_pix_valid & i_pix_ready;
  // A slot freed by this cycle's pop is usable for the request issued now.
  assign room         = (occupancy < DEPTH_V) | pop;
  assign last_word    = (word_cnt == LAST_IDX);
  assign o_busy       = (state != IDLE);
  assign o_sram_write = 1'b0;
  // Counter only advances on done, so the address holds through the wait.
  assign o_sram_addr  = base + {16'd0, word_cnt};

  always_comb begin
    state_nxt   = state;
    o_sram_read = 1'b0;
    o_line_done = 1'b0;
    push        = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nxt = CHECK;
      end
      CHECK: begin
        if (room) begin
          o_sram_read = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (i_sram_done) begin
          push = 1'b1;
          if (last_word) begin
            o_line_done = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      base     <= '0;
      word_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_start) begin
        base     <= i_line_base;
        word_cnt <= '0;
      end else if (push) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= i_sram_data;
  end

endmodule
